// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a big-endian byte stream, writes 32-bit words
// into imem, and releases cpu_reset only after a trailing XOR checksum matches.
//
// state | meaning
// IDLE  | waiting for start after reset
// RECV  | assembling the next word from accepted bytes
// WRITE | one-cycle mem_we pulse for the assembled word
// CHECK | waiting for the checksum byte
// DONE  | load good, pipeline released
// ERR   | bad count or bad checksum, pipeline held
module imem_loader #(
    parameter int          WORDS = 64,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [1:0]     bcnt_q, bcnt_d;
    logic [7:0]     xor_q, xor_d;
    logic [31:0]    word_q, word_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           accept;
    logic           last_word;

    assign in_ready  = (state_q == RECV) || (state_q == CHECK);
    assign accept    = in_valid && in_ready;
    assign last_word = (int'(idx_q) + 1) == int'(cnt_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        xor_d   = xor_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    if (word_count == 8'd0 || int'(word_count) > WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = RECV;
                        idx_d   = '0;
                        bcnt_d  = 2'd0;
                        xor_d   = 8'd0;
                        cnt_d   = word_count;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    word_d = {word_q[23:0], in_byte};
                    xor_d  = xor_q ^ in_byte;
                    bcnt_d = bcnt_q + 2'd1;
                    // only a complete word ever reaches the memory port
                    if (bcnt_q == 2'd3) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        addr_d  = BASE + (32'(idx_q) << 2);
                        wdata_d = {word_q[23:0], in_byte};
                    end
                end
            end
            WRITE: begin
                if ((int'(idx_q) + 1) == WORDS) idx_d = '0;
                else                            idx_d = idx_q + IW'(1);
                state_d = last_word ? CHECK : RECV;
            end
            CHECK: begin
                if (accept) state_d = (in_byte == xor_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bcnt_q  <= 2'd0;
            xor_q   <= 8'd0;
            word_q  <= 32'd0;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            xor_q   <= xor_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_reset = (state_q != DONE);
    assign busy      = (state_q == RECV) || (state_q == WRITE) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WORDS, default 64, capacity of the instruction memory in 32-bit words.
REQ-002 Parameter BASE, default 32'h0000_0000, byte address of the first loaded word.
REQ-003 clock  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 word_count  input  8  number of words to load; sampled only on an accepted start.
REQ-007 in_valid  input  1  a byte is present on in_byte.
REQ-008 in_byte  input  8  program byte stream, big-endian within each word.
REQ-009 in_ready  output  1  loader accepts in_byte this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe.
REQ-011 mem_addr  output  32  word-aligned byte address of the write.
REQ-012 mem_wdata  output  32  instruction word to write.
REQ-013 cpu_reset  output  1  holds the pipeline in reset.
REQ-014 busy  output  1  a session is in progress.
REQ-015 done  output  1  the last load completed with a valid checksum.
REQ-016 error  output  1  the last load failed.

Function
REQ-017 The FSM SHALL have the states IDLE, RECV, WRITE, CHECK, DONE and ERR.
REQ-018 A byte SHALL be accepted only on a rising edge where in_valid and in_ready are both 1.
REQ-019 in_ready SHALL be 1 only in RECV and CHECK.
REQ-020 From IDLE, DONE or ERR, start with 1 <= word_count <= WORDS SHALL move to RECV on the next cycle.
REQ-021 On the transition in REQ-020, the loader SHALL clear the word index, the byte counter and the running XOR, and clear done and error.
REQ-022 From IDLE, DONE or ERR, start with word_count == 0 or word_count > WORDS SHALL go to ERR.
REQ-023 start SHALL be ignored in RECV, WRITE and CHECK.
REQ-024 In RECV, accepted bytes SHALL fill the word MSB-first: byte 0 -> [31:24], byte 3 -> [7:0].
REQ-025 Every accepted data byte SHALL be XORed into an 8-bit running checksum.
REQ-026 The 4th accepted byte of a word SHALL move the FSM to WRITE on the next cycle.
REQ-027 WRITE SHALL last exactly one cycle with mem_we = 1, mem_addr = BASE + 4*index and mem_wdata = the assembled word.
REQ-028 After WRITE, the index SHALL increment (modulo WORDS) and the FSM SHALL move to RECV, or to CHECK if index+1 == word_count.
REQ-029 In CHECK, one accepted byte SHALL be compared with the running XOR: equal -> DONE, unequal -> ERR.
REQ-030 mem_we SHALL be 0 in every state except WRITE.
REQ-031 mem_addr and mem_wdata SHALL hold their last values outside WRITE.
REQ-032 cpu_reset SHALL be 1 in every state except DONE.
REQ-033 busy SHALL be 1 in RECV, WRITE and CHECK.
REQ-034 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR.
REQ-035 in_valid with in_ready = 0 SHALL be ignored with no state change; idle gaps between bytes SHALL be tolerated without timeout.
REQ-036 A partially received word SHALL never be written to memory.

Reset
REQ-037 reset SHALL take priority over all inputs, including start and in_valid.
REQ-038 On reset, state SHALL be IDLE and in_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_reset = 1, busy = 0, done = 0, error = 0.
REQ-039 On reset, the index, the byte counter and the XOR SHALL be 0.
REQ-040 Reset in the middle of a session SHALL discard any partial word, with no mem_we pulse in the following cycle.

Verification
REQ-041 Single word: start with word_count = 1, bytes 20 08 00 05, then checksum 2D -> exactly one mem_we pulse with addr 0 and wdata 32'h2008_0005; then done = 1, cpu_reset = 0.
REQ-042 Bad checksum: the stream of REQ-041 with checksum 2C -> ERR, error = 1, cpu_reset stays 1, and the single write still occurred.
REQ-043 Three words 0x20080005, 0x20090003, 0x01095020 with checksum = XOR of all 12 bytes -> writes to addr 0, 4 and 8 in order, then DONE.
REQ-044 Illegal count: word_count = 0, and separately word_count = 65 with WORDS = 64 -> ERR in the next cycle, no mem_we, in_ready stays 0.
REQ-045 Reset after 2 bytes of word 1, then a fresh load -> no write from the aborted session; the new load writes starting at addr 0.
REQ-046 Back-pressure and restart: in_valid toggling randomly, and start pulsed mid-RECV -> no byte lost or duplicated, start ignored, and the checksum still matches.
